// File: rtl/fib_pkg.sv
// Shared types and constants for the fibonacci engine scheduler.
package fib_pkg;

    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               any,
    output logic [ID_W-1:0]    winner
);

    // NOTE: every output of a combinational block gets a default before the
    // loop, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        int idx;
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fib_sched.sv
// Round-robin scheduler sharing one fibonacci engine among NUM_REQ requesters.
// Optional result cache enabled by defining FIB_CACHE_EN.
module fib_sched
    import fib_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_din,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_dout,
    output logic                      busy,
    output logic                      eng_start,
    output logic [DATA_W-1:0]         eng_din,
    input  logic [DATA_W-1:0]         eng_dout,
    input  logic                      eng_done
);

    localparam int ID_W = $clog2(NUM_REQ);

    sched_state_t        state, state_d;
    logic [ID_W-1:0]     cur_id, cur_id_d;
    logic [ID_W-1:0]     rr_ptr, rr_ptr_d;
    logic [DATA_W-1:0]   eng_din_d, rsp_dout_d;
    logic [NUM_REQ-1:0]  ack_d, rsp_valid_d;
    logic                busy_d, eng_start_d;

    logic                pick_any;
    logic [ID_W-1:0]     pick_id;
    logic [DATA_W-1:0]   pick_din;

    logic                grant_hit;
    logic                issue_hit;
    logic [DATA_W-1:0]   hit_dout;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .any    (pick_any),
        .winner (pick_id)
    );

    assign pick_din = req_din[pick_id*DATA_W +: DATA_W];

`ifdef FIB_CACHE_EN
    logic [DATA_W-1:0] cache_din;
    logic [DATA_W-1:0] cache_dout;
    logic              cache_vld;
    logic              hit_q;

    // The hit is resolved at grant time against the operand being latched; the
    // cache only changes in WAIT, so this equals comparing eng_din in ISSUE.
    assign grant_hit = cache_vld && (pick_din == cache_din);
    assign issue_hit = hit_q;
    assign hit_dout  = cache_dout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cache_din  <= '0;
            cache_dout <= '0;
            cache_vld  <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            if (state == WAIT && eng_done) begin
                cache_din  <= eng_din;
                cache_dout <= eng_dout;
                cache_vld  <= 1'b1;
            end
            if (state == IDLE) begin
                hit_q <= grant_hit;
            end
        end
    end
`else
    assign grant_hit = 1'b0;
    assign issue_hit = 1'b0;
    assign hit_dout  = '0;
`endif

    // Every output is registered, so the next-state logic also computes the
    // value each output must show while in the state being entered.
    always_comb begin
        state_d     = state;
        cur_id_d    = cur_id;
        rr_ptr_d    = rr_ptr;
        eng_din_d   = eng_din;
        rsp_dout_d  = rsp_dout;
        ack_d       = '0;
        rsp_valid_d = '0;
        eng_start_d = 1'b0;

        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_d        = ISSUE;
                    cur_id_d       = pick_id;
                    rr_ptr_d       = pick_id;
                    eng_din_d      = pick_din;
                    ack_d[pick_id] = 1'b1;
                    eng_start_d    = !grant_hit;
                end
            end
            ISSUE: begin
                if (issue_hit) begin
                    state_d             = RESP;
                    rsp_dout_d          = hit_dout;
                    rsp_valid_d[cur_id] = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (eng_done) begin
                    state_d             = RESP;
                    rsp_dout_d          = eng_dout;
                    rsp_valid_d[cur_id] = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cur_id    <= '0;
            rr_ptr    <= ID_W'(NUM_REQ - 1);
            eng_din   <= '0;
            rsp_dout  <= '0;
            ack       <= '0;
            rsp_valid <= '0;
            busy      <= 1'b0;
            eng_start <= 1'b0;
        end else begin
            state     <= state_d;
            cur_id    <= cur_id_d;
            rr_ptr    <= rr_ptr_d;
            eng_din   <= eng_din_d;
            rsp_dout  <= rsp_dout_d;
            ack       <= ack_d;
            rsp_valid <= rsp_valid_d;
            busy      <= busy_d;
            eng_start <= eng_start_d;
        end
    end

endmodule

// File: tb/tb_fib_sched.sv
// Directed bench for fib_sched with a behavioural fibonacci engine of fixed latency.
module tb_fib_sched;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 16;
    localparam int ENG_LAT = 4;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_din;
    logic [NUM_REQ-1:0]        ack;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_dout;
    logic                      busy;
    logic                      eng_start;
    logic [DATA_W-1:0]         eng_din;
    logic [DATA_W-1:0]         eng_dout;
    logic                      eng_done;

    logic                      spur_done;
    logic                      done_m;
    logic [DATA_W-1:0]         res;
    int                        cnt;
    int                        keep_n [NUM_REQ];

    int errors;
    int checks;

    int          cyc;
    int          done_cyc;
    int          start_cnt;
    int          ack_q [$];
    int          ack_cyc [$];
    int          rsp_id_q [$];
    logic [15:0] rsp_d_q [$];
    int          rsp_cyc [$];

    fib_sched #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_din   (req_din),
        .ack       (ack),
        .rsp_valid (rsp_valid),
        .rsp_dout  (rsp_dout),
        .busy      (busy),
        .eng_start (eng_start),
        .eng_din   (eng_din),
        .eng_dout  (eng_dout),
        .eng_done  (eng_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] fib(input logic [15:0] n);
        logic [15:0] a, b, t;
        a = 16'd0;
        b = 16'd1;
        for (int i = 0; i < int'(n); i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Engine model: done pulses ENG_LAT cycles after the start cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= 0;
            done_m <= 1'b0;
            res    <= '0;
        end else begin
            done_m <= (cnt == 1);
            if (eng_start) begin
                cnt <= ENG_LAT - 1;
                res <= fib(eng_din);
            end else if (cnt != 0) begin
                cnt <= cnt - 1;
            end
        end
    end

    assign eng_done = done_m | spur_done;
    assign eng_dout = spur_done ? 16'd777 : res;

    initial begin
        cyc       = 0;
        done_cyc  = -1;
        start_cnt = 0;
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ack[i]) begin
                ack_q.push_back(i);
                ack_cyc.push_back(cyc);
            end
            if (rsp_valid[i]) begin
                rsp_id_q.push_back(i);
                rsp_d_q.push_back(rsp_dout);
                rsp_cyc.push_back(cyc);
            end
        end
        if (eng_start) start_cnt = start_cnt + 1;
        if (eng_done) done_cyc = cyc;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    // One cycle; requesters drop req on ack unless they have queued repeats.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ack[i]) begin
                    if (keep_n[i] > 0) keep_n[i] = keep_n[i] - 1;
                    else req[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic issue(input int id, input logic [15:0] din, input int repeats);
        req_din[id*DATA_W +: DATA_W] = din;
        keep_n[id] = repeats;
        req[id]    = 1'b1;
    endtask

    task automatic wait_rsp(input int target, input string name);
        int budget;
        budget = 400;
        while ((rsp_id_q.size() < target || busy) && budget > 0) begin
            step(1);
            budget--;
        end
        checks++;
        if (rsp_id_q.size() < target || busy) begin
            errors++;
            $display("FAIL %s_timeout: responses=%0d busy=%b required responses=%0d busy=0",
                     name, rsp_id_q.size(), busy, target);
        end
    endtask

    task automatic wait_ack(input int target, input string name);
        int budget;
        budget = 400;
        while (ack_q.size() < target && budget > 0) begin
            step(1);
            budget--;
        end
        checks++;
        if (ack_q.size() < target) begin
            errors++;
            $display("FAIL %s_ack_timeout: acks=%0d required=%0d", name, ack_q.size(), target);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req       = '0;
        req_din   = '0;
        spur_done = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) keep_n[i] = 0;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        step(1);
        checks++;
        if ({ack, rsp_valid, eng_start, busy} !== 10'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ack=%b rsp_valid=%b eng_start=%b busy=%b required all 0",
                     ack, rsp_valid, eng_start, busy);
        end
        checks++;
        if ({rsp_dout, eng_din} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: rsp_dout=%0d eng_din=%0d required 0/0", rsp_dout, eng_din);
        end
        reset = 1'b0;
        step(2);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_single();
        int ab, rb;
        ab = ack_q.size();
        rb = rsp_id_q.size();
        issue(0, 16'd10, 0);
        step(1);
        checks++;
        if (ack !== 4'b0001 || eng_start !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_ack: ack=%b eng_start=%b busy=%b required 0001/1/1",
                     ack, eng_start, busy);
        end
        checks++;
        if (eng_din !== 16'd10) begin
            errors++;
            $display("FAIL single_eng_din: got %0d required 10", eng_din);
        end
        wait_rsp(rb + 1, "single");
        if (rsp_id_q.size() > rb) begin
            checks++;
            if (rsp_id_q[rb] !== 0 || rsp_d_q[rb] !== 16'd55) begin
                errors++;
                $display("FAIL single_rsp: id=%0d dout=%0d required 0/55", rsp_id_q[rb], rsp_d_q[rb]);
            end
            checks++;
            if (rsp_cyc[rb] != done_cyc + 1) begin
                errors++;
                $display("FAIL single_rsp_latency: rsp cycle=%0d required %0d", rsp_cyc[rb], done_cyc + 1);
            end
        end
        checks++;
        if (ack_q.size() - ab != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_ack_count: acks=%0d busy=%b required 1/0", ack_q.size() - ab, busy);
        end
    endtask

    task automatic test_all4();
        int ab, rb;
        logic [15:0] exp_d [4];
        exp_d = '{16'd5, 16'd8, 16'd13, 16'd21};
        do_reset();
        ab = ack_q.size();
        rb = rsp_id_q.size();
        for (int i = 0; i < NUM_REQ; i++) issue(i, 16'(5 + i), 0);
        wait_rsp(rb + 4, "all4");
        checks++;
        if (ack_q.size() - ab != 4 || rsp_id_q.size() - rb != 4) begin
            errors++;
            $display("FAIL all4_counts: acks=%0d rsps=%0d required 4/4", ack_q.size() - ab, rsp_id_q.size() - rb);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (ack_q[ab+k] != k || rsp_id_q[rb+k] != k || rsp_d_q[rb+k] !== exp_d[k]) begin
                    errors++;
                    $display("FAIL all4_order_%0d: ack id=%0d rsp id=%0d dout=%0d required %0d/%0d/%0d",
                             k, ack_q[ab+k], rsp_id_q[rb+k], rsp_d_q[rb+k], k, k, exp_d[k]);
                end
            end
        end
    endtask

    task automatic test_fairness();
        int ab, rb;
        int exp_id [4];
        logic [15:0] exp_d [4];
        exp_id = '{2, 3, 0, 2};
        exp_d  = '{16'd34, 16'd89, 16'd144, 16'd34};
        ab = ack_q.size();
        rb = rsp_id_q.size();
        issue(2, 16'd9, 1);
        wait_ack(ab + 1, "fair");
        issue(3, 16'd11, 0);
        issue(0, 16'd12, 0);
        wait_rsp(rb + 4, "fair");
        checks++;
        if (ack_q.size() - ab != 4 || rsp_id_q.size() - rb != 4) begin
            errors++;
            $display("FAIL fair_counts: acks=%0d rsps=%0d required 4/4", ack_q.size() - ab, rsp_id_q.size() - rb);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (ack_q[ab+k] != exp_id[k] || rsp_id_q[rb+k] != exp_id[k] || rsp_d_q[rb+k] !== exp_d[k]) begin
                    errors++;
                    $display("FAIL fair_order_%0d: ack id=%0d rsp id=%0d dout=%0d required %0d/%0d/%0d",
                             k, ack_q[ab+k], rsp_id_q[rb+k], rsp_d_q[rb+k], exp_id[k], exp_id[k], exp_d[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int ab, rb;
        ab = ack_q.size();
        rb = rsp_id_q.size();
        issue(0, 16'd3, 1);
        wait_ack(ab + 1, "b2b");
        req_din[0 +: DATA_W] = 16'd4;
        wait_rsp(rb + 2, "b2b");
        if (ack_q.size() - ab == 2 && rsp_id_q.size() - rb == 2) begin
            checks++;
            if (ack_cyc[ab+1] - ack_cyc[ab] != ENG_LAT + 3) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d cycles required %0d", ack_cyc[ab+1] - ack_cyc[ab], ENG_LAT + 3);
            end
            checks++;
            if (rsp_d_q[rb] !== 16'd2 || rsp_d_q[rb+1] !== 16'd3 || ack_q[ab+1] != 0) begin
                errors++;
                $display("FAIL b2b_data: dout=%0d,%0d id=%0d required 2,3 id 0",
                         rsp_d_q[rb], rsp_d_q[rb+1], ack_q[ab+1]);
            end
        end else begin
            checks++;
            errors++;
            $display("FAIL b2b_counts: acks=%0d rsps=%0d required 2/2", ack_q.size() - ab, rsp_id_q.size() - rb);
        end
    endtask

    task automatic test_edge();
        int ab, rb;
        rb = rsp_id_q.size();
        issue(1, 16'd0, 0);
        wait_rsp(rb + 1, "din0");
        issue(2, 16'd1, 0);
        wait_rsp(rb + 2, "din1");
        if (rsp_id_q.size() - rb == 2) begin
            checks++;
            if (rsp_d_q[rb] !== 16'd0 || rsp_d_q[rb+1] !== 16'd1) begin
                errors++;
                $display("FAIL edge_din01: dout=%0d,%0d required 0,1", rsp_d_q[rb], rsp_d_q[rb+1]);
            end
        end
        ab = ack_q.size();
        rb = rsp_id_q.size();
        step(1);
        spur_done = 1'b1;
        step(1);
        spur_done = 1'b0;
        step(4);
        checks++;
        if (rsp_id_q.size() != rb || ack_q.size() != ab || busy !== 1'b0 || rsp_dout !== 16'd1) begin
            errors++;
            $display("FAIL spurious_done: rsps=%0d acks=%0d busy=%b rsp_dout=%0d required 0/0/0/1",
                     rsp_id_q.size() - rb, ack_q.size() - ab, busy, rsp_dout);
        end
    endtask

    task automatic test_reset_mid();
        int ab, rb, sb;
        ab = ack_q.size();
        rb = rsp_id_q.size();
        issue(1, 16'd15, 0);
        wait_ack(ab + 1, "mid");
        step(2);
        checks++;
        if (busy !== 1'b1 || eng_start !== 1'b0 || eng_din !== 16'd15) begin
            errors++;
            $display("FAIL mid_wait: busy=%b eng_start=%b eng_din=%0d required 1/0/15", busy, eng_start, eng_din);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({ack, rsp_valid, eng_start, busy, rsp_dout, eng_din} !== 42'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: ack=%b rsp_valid=%b eng_start=%b busy=%b rsp_dout=%0d eng_din=%0d required all 0",
                     ack, rsp_valid, eng_start, busy, rsp_dout, eng_din);
        end
        step(1);
        reset = 1'b0;
        step(8);
        checks++;
        if (rsp_id_q.size() != rb || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_dropped: rsps=%0d busy=%b required 0/0", rsp_id_q.size() - rb, busy);
        end
        sb = start_cnt;
        issue(3, 16'd20, 0);
        wait_rsp(rb + 1, "after_reset");
        if (rsp_id_q.size() > rb) begin
            checks++;
            if (rsp_id_q[rb] != 3 || rsp_d_q[rb] !== 16'd6765 || start_cnt != sb + 1) begin
                errors++;
                $display("FAIL after_reset_rsp: id=%0d dout=%0d starts=%0d required 3/6765/1",
                         rsp_id_q[rb], rsp_d_q[rb], start_cnt - sb);
            end
        end
    endtask

    task automatic test_cache();
        int ab, rb, sb;
        ab = ack_q.size();
        rb = rsp_id_q.size();
        sb = start_cnt;
        issue(0, 16'd20, 0);
        wait_rsp(rb + 1, "repeat20");
        if (rsp_id_q.size() > rb && ack_q.size() > ab) begin
            checks++;
            if (rsp_id_q[rb] != 0 || rsp_d_q[rb] !== 16'd6765) begin
                errors++;
                $display("FAIL repeat20_rsp: id=%0d dout=%0d required 0/6765", rsp_id_q[rb], rsp_d_q[rb]);
            end
`ifdef FIB_CACHE_EN
            checks++;
            if (start_cnt != sb || rsp_cyc[rb] - ack_cyc[ab] != 1) begin
                errors++;
                $display("FAIL cache_hit: starts=%0d ack-to-rsp=%0d required 0/1",
                         start_cnt - sb, rsp_cyc[rb] - ack_cyc[ab]);
            end
`else
            checks++;
            if (start_cnt != sb + 1 || rsp_cyc[rb] - ack_cyc[ab] != ENG_LAT + 1) begin
                errors++;
                $display("FAIL no_cache: starts=%0d ack-to-rsp=%0d required 1/%0d",
                         start_cnt - sb, rsp_cyc[rb] - ack_cyc[ab], ENG_LAT + 1);
            end
`endif
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single();
        test_all4();
        test_fairness();
        test_back_to_back();
        test_edge();
        test_reset_mid();
        test_cache();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fib_sched.md
Name: fib_sched

Overview:
- Round-robin scheduler that shares one fibonacci engine (din/start/dout/done) among NUM_REQ requesters.
- Each request is accepted, its operand is issued to the engine, the engine waits for done, and the result is returned to the requester that issued it.
- Sits between the client blocks and the single fibonacci instance. Uses the same clock and reset as the engine.

Parameters:
- NUM_REQ, 4, number of requesters (2..16); ID_W = $clog2(NUM_REQ) is a derived localparam.
- DATA_W, 16, operand/result width; must match the engine width.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level.
- req_din  in  NUM_REQ*DATA_W  operands, packed; requester i at [i*DATA_W +: DATA_W].
- ack  out  NUM_REQ  one-hot, one-cycle pulse: request accepted.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: result ready for requester i.
- rsp_dout  out  DATA_W  result; valid only while rsp_valid is nonzero.
- busy  out  1  high in any state other than IDLE.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_din  out  DATA_W  operand to the engine; held stable from ISSUE through WAIT.
- eng_dout  in  DATA_W  engine result.
- eng_done  in  1  engine completion.

Behaviour:
- Reset: all outputs are 0; state=IDLE; cur_id=0; rr_ptr=NUM_REQ-1, so requester 0 has first priority.
- Reset is honoured at any point, including mid-operation. The in-flight request is dropped and no rsp_valid is produced.
- All outputs are registered.
- State sequence: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req bit is set, pick the first set bit searching from rr_ptr+1, with wrap-around modulo NUM_REQ.
  - At the clock edge: cur_id<=winner, eng_din<=req_din[winner], rr_ptr<=winner, go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE (1 cycle): ack[cur_id]=1 and eng_start=1, then go to WAIT.
- WAIT:
  - eng_start=0; eng_din is held.
  - On eng_done=1: rsp_dout<=eng_dout and go to RESP.
  - No timeout.
- RESP (1 cycle): rsp_valid[cur_id]=1, then go to IDLE. rsp_dout holds its value until the next RESP.
- Latency:
  - Request sampled at edge T; ack and eng_start high in cycle T+1.
  - rsp_valid high one cycle after eng_done is sampled.
  - Minimum spacing between two grants is engine latency + 3 cycles.
- Requester protocol:
  - Hold req and req_din stable until ack.
  - Drop req on ack, or keep it high to queue the next request.
  - A req high in IDLE is treated as a new request.
- Arbitration rules:
  - req bits asserted outside IDLE are not sampled; they wait for IDLE.
  - The requester served last has lowest priority at the next arbitration.
  - A lone requester is served back-to-back.
- eng_done outside WAIT is ignored.
- din 0 and 1 pass through unchanged; the engine handles them.

Optional Feature:
- Macro: FIB_CACHE_EN.
- Defined:
  - Registers cache_din, cache_dout and cache_vld; cache_vld is cleared on reset.
  - Each eng_done in WAIT writes the cache: cache_din<=eng_din, cache_dout<=eng_dout, cache_vld<=1.
  - In ISSUE, if cache_vld and eng_din==cache_din (hit): ack pulses, eng_start stays 0, rsp_dout<=cache_dout, go directly to RESP.
  - A hit gives a 3-cycle request-to-rsp_valid turnaround.
- Undefined: no cache registers; every request goes through the engine.

Decomposition:
- Package fib_pkg:
  - DATA_W default constant.
  - sched_state_t enum {IDLE, ISSUE, WAIT, RESP}, 2 bits.
- Sub-module rr_pick, purely combinational:
  - Inputs: req[NUM_REQ], ptr[ID_W].
  - Outputs: any, winner[ID_W].
- fib_sched holds the FSM, registers and cache; the fibonacci engine is instantiated by the parent, not inside fib_sched.

Test Plan:
- Reset, then req[0]=1 with din=10 → ack[0] one cycle later; eng_din=10; rsp_valid[0] pulse with rsp_dout=55; busy returns to 0.
- req[0..3] all set simultaneously with din 5/6/7/8 → served in order 0,1,2,3 with results 5/8/13/21; exactly one ack and one rsp_valid per requester.
- Requester 2 keeps req high after its grant while requester 3 also requests → grant order 3 then 2 (round-robin fairness); wrap-around from 3 to 0 checked.
- din=0 and din=1 → rsp_dout 0 and 1; spurious eng_done pulse during IDLE → no response, state unchanged.
- Assert reset during WAIT → all outputs 0 next cycle, no rsp_valid; a following request with din=20 returns 6765.
- FIB_CACHE_EN: din=20 twice from different requesters → second has no eng_start pulse, rsp_dout=6765, 3-cycle turnaround. Without the macro, the second request pulses eng_start.
